wb_initiator: RTL and testbench

Wishbone classic single-transfer bus initiator driving the shared user-macro Wishbone bus, i.e. the master end of the interface every user macro answers as a responder. Accepts one read or write command on a valid/ready port, runs one Wishbone cycle with a bounded-wait timeout, and returns the read data and an error flag on a valid/ready response port. Used for on-chip bring-up and self-test of the macro array without the external management core.

---
 rtl/wb_initiator.sv | 93 +++++++++
 tb/tb_wb_initiator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// wb_initiator: single-transfer Wishbone classic initiator with bounded-wait timeout
module wb_initiator #(
  parameter int WB_data_bits   = 32,
  parameter int WB_addr_bits   = 32,
  parameter int WB_select_bits = WB_data_bits / 8,
  parameter int timeout_cycles = 255,
  parameter int tmo_bits       = $clog2(timeout_cycles + 1)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [WB_addr_bits-1:0]   cmd_adr_i,
  input  logic [WB_data_bits-1:0]   cmd_dat_i,
  input  logic [WB_select_bits-1:0] cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WB_data_bits-1:0]   rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [WB_select_bits-1:0] wbm_sel_o,
  output logic [WB_addr_bits-1:0]   wbm_adr_o,
  output logic [WB_data_bits-1:0]   wbm_dat_o,
  input  logic                      wbm_ack_i,
  input  logic [WB_data_bits-1:0]   wbm_dat_i
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [tmo_bits-1:0] TMO_LAST = tmo_bits'(timeout_cycles - 1);
  state_t                    state_q;
  logic [tmo_bits-1:0]       cnt_q;
  logic                      we_q;
  logic [WB_addr_bits-1:0]   adr_q;
  logic [WB_data_bits-1:0]   dat_q;
  logic [WB_select_bits-1:0] sel_q;
  logic [WB_data_bits-1:0]   rsp_dat_q;
  logic                      rsp_err_q;
  // Handshakes and cyc/stb are decoded from the state register only
  assign cmd_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign wbm_cyc_o   = state_q == BUS;
  assign wbm_stb_o   = state_q == BUS;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  // Command latch, bus cycle with timeout, and response hold; bus fields clear on leaving BUS
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          we_q    <= cmd_we_i;
          adr_q   <= cmd_adr_i;
          dat_q   <= cmd_we_i ? cmd_dat_i : '0;
          sel_q   <= cmd_sel_i;
          cnt_q   <= '0;
          state_q <= BUS;
        end
        BUS: begin
          cnt_q <= cnt_q + 1'b1;
          if (wbm_ack_i || cnt_q == TMO_LAST) begin
            rsp_dat_q <= (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
            rsp_err_q <= !wbm_ack_i;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            state_q   <= RESP;
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_dat_q <= '0;
          rsp_err_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: vector table plus scoreboard bench for wb_initiator (timeout of 4)
module tb_wb_initiator;
  localparam int TMO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack = 1'b0;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i = '0;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] rdat;
    int          hold;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;
  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  vec_t vecs[7];
  rsp_t exp_q[$];
  wb_initiator #(.timeout_cycles(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_txn(input vec_t v);
    int n;
    rsp_t e;
    chk("idle_ready", {31'b0, cmd_ready}, 32'd1);
    chk("idle_cyc", {31'b0, cyc}, 32'd0);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    exp_q.push_back('{dat: v.exp_dat, err: v.exp_err});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
    n = 0;
    while (cyc && n < 8) begin
      chk("bus_stb", {31'b0, stb}, 32'd1);
      chk("bus_we", {31'b0, we}, {31'b0, v.we});
      chk("bus_adr", adr, v.adr);
      chk("bus_sel", {28'b0, sel}, {28'b0, v.sel});
      chk("bus_dat", dat_o, v.we ? v.dat : 32'h0);
      chk("bus_no_rsp", {31'b0, rsp_valid}, 32'd0);
      ack = (n == v.waits);
      dat_i = ack ? v.rdat : $urandom;
      @(negedge clk);
      n++;
    end
    chk("bus_cycles", n, (v.waits < TMO) ? v.waits + 1 : TMO);
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_stb_low", {31'b0, stb}, 32'd0);
    for (int j = 0; j < v.hold; j++) begin
      ack = 1'b1; dat_i = $urandom;
      cmd_valid = 1'b1; cmd_we = $urandom; cmd_adr = $urandom; cmd_sel = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_ready", {31'b0, cmd_ready}, 32'd0);
      chk("hold_cyc", {31'b0, cyc}, 32'd0);
      if (exp_q.size() > 0) begin
        chk("hold_dat", rsp_dat, exp_q[0].dat);
        chk("hold_err", {31'b0, rsp_err}, {31'b0, exp_q[0].err});
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: response with empty queue at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_dat", rsp_dat, e.dat);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    end
    @(negedge clk);
    rsp_ready = 1'b0; ack = 1'b0;
    chk("after_ready", {31'b0, cmd_ready}, 32'd1);
    chk("after_valid", {31'b0, rsp_valid}, 32'd0);
  endtask
  initial begin
    vecs[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 0, 32'h0,         0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 9, 32'h0,         2, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h3000_0030, 32'h0,         4'hF, 3, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b1, 32'h3000_0040, 32'h1122_3344, 4'h3, 1, 32'hFFFF_FFFF, 5, 32'h0,         1'b0};
    vecs[5] = '{1'b1, 32'h3000_0050, 32'h5555_AAAA, 4'hC, 9, 32'h0,         1, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 32'h3000_0060, 32'h0,         4'h1, 2, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0};
    #1;
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_cyc", {30'b0, cyc, stb}, 32'd0);
    chk("rst_we_sel", {27'b0, we, sel}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0070; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("arst_bus1", {31'b0, cyc}, 32'd1);
    @(negedge clk);
    chk("arst_bus2", {31'b0, cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", {30'b0, cyc, stb}, 32'd0);
    chk("arst_adr", adr, 32'd0);
    chk("arst_sel", {28'b0, sel}, 32'd0);
    chk("arst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("arst_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_cyc", {31'b0, cyc}, 32'd0);
    end
    ack = 1'b0;
    run_txn(vecs[1]);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
